// File: rtl/kosei_pcm_pkg.sv
// kosei_pcm_pkg: shared modes, FSM encoding and LFSR constants for the PCM pattern generator
package kosei_pcm_pkg;
  localparam logic [2:0] MODE_RAMP    = 3'd0;
  localparam logic [2:0] MODE_SQUARE  = 3'd1;
  localparam logic [2:0] MODE_IMPULSE = 3'd2;
  localparam logic [2:0] MODE_CONST   = 3'd3;
  localparam logic [2:0] MODE_NOISE   = 3'd4;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PEND, ST_DONE} state_t;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction
endpackage

// File: rtl/kosei_lfsr32.sv
// kosei_lfsr32: 32-bit Galois LFSR, reloads its seed on load, steps on en, exposes top OUT_W bits
module kosei_lfsr32
  import kosei_pcm_pkg::*;
#(
  parameter logic [31:0] SEED  = LFSR_SEED,
  parameter int          OUT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  output logic [OUT_W-1:0] y
);
  logic [31:0] q;
  assign y = q[31 -: OUT_W];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= SEED;
    else if (load) q <= SEED;
    else if (en) q <= lfsr_next(q);
endmodule

// File: rtl/kosei_pcm_pattern_gen.sv
// kosei_pcm_pattern_gen: multi-channel PCM pattern source with rate divider, bursts and valid/ready output
module kosei_pcm_pattern_gen
  import kosei_pcm_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cfg_start,
  input  logic                     cfg_stop,
  input  logic [2:0]               cfg_mode,
  input  logic [DATA_W-1:0]        cfg_step,
  input  logic [DIV_W-1:0]         cfg_period,
  input  logic [DIV_W-1:0]         cfg_rate_div,
  input  logic [15:0]              cfg_burst_len,
  input  logic                     pcm_ready,
  output logic                     pcm_valid,
  output logic [NUM_CH*DATA_W-1:0] pcm_data,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              sample_count
);
  state_t            state, state_nx;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nx, period_s, rate_s, sq_cnt;
  logic [2:0]        mode_s;
  logic [DATA_W-1:0] step_s;
  logic [15:0]       burst_s, count_nx;
  logic              sq_neg, first, go, accept, sq_last;
  logic [DATA_W-1:0] acc [NUM_CH];
  logic [DATA_W-1:0] noise [NUM_CH];
  assign go        = state == ST_IDLE && cfg_start && !cfg_stop;
  assign accept    = state == ST_PEND && pcm_ready && !cfg_stop;
  assign count_nx  = sample_count + 16'd1;
  assign sq_last   = period_s <= DIV_W'(1) || sq_cnt == period_s - DIV_W'(1);
  assign pcm_valid = state == ST_PEND;
  assign busy      = state != ST_IDLE;
  assign done      = state == ST_DONE;
  always_comb begin
    state_nx   = state;
    div_cnt_nx = div_cnt;
    case (state)
      ST_IDLE: state_nx = go ? ST_PEND : ST_IDLE;
      ST_PEND:
        if (cfg_stop) state_nx = ST_IDLE;
        else if (pcm_ready) begin
          if (burst_s != 16'd0 && count_nx == burst_s) state_nx = ST_DONE;
          else if (rate_s > DIV_W'(1)) begin
            state_nx   = ST_WAIT;
            div_cnt_nx = rate_s - DIV_W'(2);
          end
        end
      ST_WAIT:
        if (cfg_stop) state_nx = ST_IDLE;
        else if (div_cnt == '0) state_nx = ST_PEND;
        else div_cnt_nx = div_cnt - DIV_W'(1);
      default: state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_cnt_nx;
    end
  // Config is shadowed at start; generator state only moves on an accepted sample
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mode_s       <= '0;
      step_s       <= '0;
      period_s     <= '0;
      rate_s       <= '0;
      burst_s      <= '0;
      sample_count <= '0;
      sq_cnt       <= '0;
      sq_neg       <= 1'b0;
      first        <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
    end else if (go) begin
      mode_s       <= cfg_mode;
      step_s       <= cfg_step;
      period_s     <= cfg_period;
      rate_s       <= cfg_rate_div;
      burst_s      <= cfg_burst_len;
      sample_count <= '0;
      sq_cnt       <= '0;
      sq_neg       <= 1'b0;
      first        <= 1'b1;
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
    end else if (accept) begin
      sample_count <= count_nx;
      sq_cnt       <= sq_last ? '0 : sq_cnt + DIV_W'(1);
      sq_neg       <= sq_neg ^ sq_last;
      first        <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) acc[k] <= acc[k] + step_s * DATA_W'(k + 1);
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    kosei_lfsr32 #(.SEED(LFSR_SEED + 32'(i)), .OUT_W(DATA_W)) u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (go),
      .en      (accept),
      .y       (noise[i])
    );
    assign pcm_data[i*DATA_W +: DATA_W] =
      state != ST_PEND         ? '0 :
      mode_s == MODE_RAMP      ? acc[i] :
      mode_s == MODE_SQUARE    ? (sq_neg ? -step_s : step_s) :
      mode_s == MODE_IMPULSE   ? (first ? {1'b0, {(DATA_W-1){1'b1}}} : '0) :
      mode_s == MODE_CONST     ? step_s :
      mode_s == MODE_NOISE     ? noise[i] : '0;
  end
endmodule
